// File: rtl/pwm_sample_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_sample_scheduler
//
// Sample-rate controller that feeds 8-bit audio samples to the PWM and
// sigma-delta modulators. Incoming samples are buffered in a small FIFO with a
// valid/ready handshake. One sample is released every FRAMES_PER_SAMPLE PWM
// frames of 256 cycles. The output changes only on a frame boundary, so no PWM
// period is ever cut short. A small FSM handles prefill, underrun and mute.
//
// Parameters
//   DEPTH             FIFO entries (power of two, >= 2)
//   FRAMES_PER_SAMPLE 256-cycle PWM frames per audio sample (>= 1)
//   MIDSCALE          value driven to the modulators while silent
//
// Ports
//   clk           clock
//   rst_n         synchronous active-low reset
//   ena           global enable; when low, every register holds its value
//   in_data       audio sample from the producer
//   in_valid      producer has a sample
//   in_ready      FIFO can accept a sample (forced low while ena is low)
//   play_en       playback request, sampled only on sample boundaries
//   clr_underrun  clears the sticky underrun flag
//   sample_out    registered sample fed to the modulators
//   frame_cnt     PWM phase counter shared with the PWM comparator
//   frame_tick    one-cycle pulse while frame_cnt==255 and ena is high
//   fifo_level    FIFO occupancy, 0..DEPTH
//   state         0=IDLE, 1=PLAY, 2=UNDERRUN
//   underrun      sticky flag, set when a sample boundary finds the FIFO empty
// -----------------------------------------------------------------------------
module pwm_sample_scheduler #(
  parameter int              DEPTH             = 4,
  parameter int              FRAMES_PER_SAMPLE = 4,
  parameter logic [7:0]      MIDSCALE          = 8'h80
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         play_en,
  input  logic                         clr_underrun,
  output logic [7:0]                   sample_out,
  output logic [7:0]                   frame_cnt,
  output logic                         frame_tick,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [1:0]                   state,
  output logic                         underrun
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int FPS_W = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(DEPTH / 2);
  localparam logic [FPS_W-1:0] FPS_LAST = FPS_W'(FRAMES_PER_SAMPLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_UNDERRUN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [FPS_W-1:0] fps_cnt;
  logic [7:0]       frame_q;
  logic [7:0]       sample_q;
  state_t           state_q;
  logic             underrun_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic       boundary;
  logic       push;
  logic       pop;
  logic       set_underrun;
  state_t     state_next;
  logic [7:0] sample_next;
  logic [7:0] head;

  assign frame_tick = ena && (frame_q == 8'hFF);
  assign boundary   = frame_tick && (fps_cnt == FPS_LAST);

  // No full-bypass: a full FIFO refuses writes even if it pops this cycle.
  assign in_ready = ena && (level_q != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // Playback FSM. It only acts on sample boundaries; between boundaries the
  // state and output hold, so play_en changes never truncate a PWM period.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_next   = state_q;
    sample_next  = sample_q;
    pop          = 1'b0;
    set_underrun = 1'b0;

    if (boundary) begin
      unique case (state_q)
        ST_IDLE: begin
          sample_next = MIDSCALE;
          if (play_en && (level_q >= HALF_LVL)) begin
            pop         = 1'b1;
            sample_next = head;
            state_next  = ST_PLAY;
          end
        end

        ST_PLAY: begin
          if (!play_en) begin
            sample_next = MIDSCALE;
            state_next  = ST_IDLE;
          end else if (level_q != '0) begin
            pop         = 1'b1;
            sample_next = head;
          end else begin
            // Starved: keep the last sample rather than jump to midscale.
            set_underrun = 1'b1;
            state_next   = ST_UNDERRUN;
          end
        end

        ST_UNDERRUN: begin
          if (!play_en) begin
            sample_next = MIDSCALE;
            state_next  = ST_IDLE;
          end else if (level_q >= HALF_LVL) begin
            // Wait for the same prefill as IDLE so playback does not stutter.
            pop         = 1'b1;
            sample_next = head;
            state_next  = ST_PLAY;
          end
        end

        default: begin
          // Encoding 3 is unreachable; recover to a silent IDLE.
          sample_next = MIDSCALE;
          state_next  = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q    <= '0;
      fps_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      sample_q   <= MIDSCALE;
      state_q    <= ST_IDLE;
      underrun_q <= 1'b0;
    end else if (ena) begin
      frame_q <= frame_q + 8'd1;

      if (frame_tick) begin
        fps_cnt <= boundary ? '0 : fps_cnt + FPS_W'(1);
      end

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      sample_q <= sample_next;
      state_q  <= state_next;

      // Set has priority over clear.
      if (set_underrun)      underrun_q <= 1'b1;
      else if (clr_underrun) underrun_q <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sample_out = sample_q;
  assign frame_cnt  = frame_q;
  assign fifo_level = level_q;
  assign state      = state_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_sample_scheduler
//
// Directed testbench for pwm_sample_scheduler with default parameters
// (DEPTH=4, FRAMES_PER_SAMPLE=4, MIDSCALE=0x80). The bench keeps its own count
// of enabled clock edges since reset; a sample boundary is the edge that takes
// that count to a multiple of 1024, and frame_cnt must equal the count mod 256.
// -----------------------------------------------------------------------------
module tb_pwm_sample_scheduler;

  localparam int CYC_PER_SAMPLE = 256 * 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       play_en;
  logic       clr_underrun;
  logic [7:0] sample_out;
  logic [7:0] frame_cnt;
  logic       frame_tick;
  logic [2:0] fifo_level;
  logic [1:0] state;
  logic       underrun;

  int n_checks = 0;
  int n_errors = 0;
  int ecyc     = 0;   // enabled edges since reset release

  pwm_sample_scheduler #(
    .DEPTH             (4),
    .FRAMES_PER_SAMPLE (4),
    .MIDSCALE          (8'h80)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .play_en      (play_en),
    .clr_underrun (clr_underrun),
    .sample_out   (sample_out),
    .frame_cnt    (frame_cnt),
    .frame_tick   (frame_tick),
    .fifo_level   (fifo_level),
    .state        (state),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (ecyc=%0d)", tag, got, exp, ecyc);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are read 1 time unit
  // after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ena && rst_n) ecyc++;
    end
  endtask

  // Run up to the cycle just before the next sample boundary, confirm the
  // output still holds, then take the boundary edge.
  task automatic to_boundary(input string tag, input logic [7:0] hold);
    while ((ecyc % CYC_PER_SAMPLE) != CYC_PER_SAMPLE - 1) step(1);
    check({tag, "_pre_hold"}, sample_out, hold);
    check({tag, "_pre_tick"}, frame_tick, 1'b1);
    step(1);
    check({tag, "_frame_wrap"}, frame_cnt, 8'd0);
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic boundary_expect(input string tag, input logic [7:0] hold,
                                 input logic [7:0] smp, input logic [1:0] st,
                                 input logic [2:0] lvl);
    to_boundary(tag, hold);
    check({tag, "_sample"}, sample_out, smp);
    check({tag, "_state"},  state,      st);
    check({tag, "_level"},  fifo_level, lvl);
  endtask

  initial begin
    rst_n        = 1'b0;
    ena          = 1'b1;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    play_en      = 1'b0;
    clr_underrun = 1'b0;

    // 1. Reset
    step(2);
    rst_n = 1'b1;
    ecyc  = 0;
    check("rst_sample",   sample_out, 8'h80);
    check("rst_state",    state,      2'd0);
    check("rst_level",    fifo_level, 3'd0);
    check("rst_ready",    in_ready,   1'b1);
    check("rst_underrun", underrun,   1'b0);
    check("rst_frame",    frame_cnt,  8'd0);

    // 2. Prefill to full, then play
    push(8'h10);
    push(8'h20);
    push(8'h30);
    push(8'h40);
    check("full_level", fifo_level, 3'd4);
    check("full_ready", in_ready,   1'b0);
    check("frame_track", frame_cnt, 8'd4);
    play_en = 1'b1;
    boundary_expect("b1", 8'h80, 8'h10, 2'd1, 3'd3);
    check("b1_ecyc", ecyc, 1024);
    boundary_expect("b2", 8'h10, 8'h20, 2'd1, 3'd2);
    boundary_expect("b3", 8'h20, 8'h30, 2'd1, 3'd1);
    boundary_expect("b4", 8'h30, 8'h40, 2'd1, 3'd0);

    // 3. Starvation, refill, recovery, clear
    boundary_expect("starve", 8'h40, 8'h40, 2'd2, 3'd0);
    check("starve_flag", underrun, 1'b1);
    push(8'h55);
    push(8'h66);
    boundary_expect("recover", 8'h40, 8'h55, 2'd1, 3'd1);
    check("recover_flag_sticky", underrun, 1'b1);
    clr_underrun = 1'b1;
    step(1);
    clr_underrun = 1'b0;
    check("clr_flag", underrun, 1'b0);

    // 4. Mute request mid-sample takes effect only at the boundary
    while ((ecyc % 256) != 100) step(1);
    check("mute_frame", frame_cnt, 8'd100);
    play_en = 1'b0;
    step(1);
    check("mute_no_immediate", sample_out, 8'h55);
    check("mute_state_hold",   state,      2'd1);
    boundary_expect("mute", 8'h55, 8'h80, 2'd0, 3'd1);

    // 5. Freeze with ena low during PLAY
    push(8'hA1);
    push(8'hA2);
    play_en = 1'b1;
    boundary_expect("replay", 8'h80, 8'h66, 2'd1, 3'd2);
    step(10);
    check("pre_freeze_frame", frame_cnt, 8'(ecyc % 256));
    ena      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    check("freeze_ready", in_ready, 1'b0);
    step(50);
    check("freeze_frame",  frame_cnt,  8'(ecyc % 256));
    check("freeze_level",  fifo_level, 3'd2);
    check("freeze_sample", sample_out, 8'h66);
    check("freeze_state",  state,      2'd1);
    check("freeze_ready2", in_ready,   1'b0);
    check("freeze_tick",   frame_tick, 1'b0);
    in_valid = 1'b0;
    ena      = 1'b1;

    // 6. Push and pop on the same boundary edge
    while ((ecyc % CYC_PER_SAMPLE) != CYC_PER_SAMPLE - 1) step(1);
    in_data  = 8'hB0;
    in_valid = 1'b1;
    check("pp_ready", in_ready, 1'b1);
    step(1);
    in_valid = 1'b0;
    check("pp_sample", sample_out, 8'hA1);
    check("pp_level",  fifo_level, 3'd2);
    boundary_expect("pp_next1", 8'hA1, 8'hA2, 2'd1, 3'd1);
    boundary_expect("pp_next2", 8'hA2, 8'hB0, 2'd1, 3'd0);

    // Set and clear of underrun on the same edge: set wins
    while ((ecyc % CYC_PER_SAMPLE) != CYC_PER_SAMPLE - 1) step(1);
    clr_underrun = 1'b1;
    step(1);
    clr_underrun = 1'b0;
    check("setclr_flag",   underrun,   1'b1);
    check("setclr_state",  state,      2'd2);
    check("setclr_sample", sample_out, 8'hB0);

    // Reset mid-operation discards FIFO contents
    push(8'hC1);
    push(8'hC2);
    check("pre_rst_level", fifo_level, 3'd2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    ecyc  = 0;
    check("mid_rst_level",    fifo_level, 3'd0);
    check("mid_rst_sample",   sample_out, 8'h80);
    check("mid_rst_state",    state,      2'd0);
    check("mid_rst_underrun", underrun,   1'b0);
    check("mid_rst_ready",    in_ready,   1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_sample_scheduler.md
Name: pwm_sample_scheduler

Overview:
Sample-rate controller sitting in front of the 8-bit PWM / first-order sigma-delta audio modulators. Buffers incoming 8-bit audio samples in a small FIFO with a valid/ready handshake. Releases one sample per N modulator frames, changing the value only on a 256-cycle PWM frame boundary so no PWM period is corrupted. Handles prefill, underrun and idle/mute sequencing.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
FRAMES_PER_SAMPLE, 4, 256-cycle PWM frames per audio sample; >= 1.
MIDSCALE, 8'h80, value driven to the modulators when idle (silence).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ena  in  1  global enable; when low, all state is frozen
in_data  in  8  audio sample from the producer
in_valid  in  1  producer has a sample
in_ready  out  1  FIFO can accept; a transfer occurs when in_valid & in_ready & ena
play_en  in  1  request playback
clr_underrun  in  1  clears the sticky underrun flag
sample_out  out  8  registered sample fed to the modulators
frame_cnt  out  8  PWM phase counter shared with the PWM comparator
frame_tick  out  1  high for one cycle when frame_cnt==255 & ena
fifo_level  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
state  out  2  0=IDLE, 1=PLAY, 2=UNDERRUN
underrun  out  1  sticky; set on a starved boundary

Behaviour:
- Reset (rst_n==0 at posedge clk): frame_cnt=0, frame-per-sample counter=0, FIFO empty (level 0, pointers 0), sample_out=MIDSCALE, state=IDLE, underrun=0. in_ready is combinational and therefore reads 1 after reset. Reset mid-operation discards all FIFO contents.
- ena low: no register changes. in_ready forced to 0, so no transfer occurs. frame_tick=0.
- frame_cnt increments by 1 each enabled cycle and wraps 255->0.
- Sample boundary: frame_tick & (fps_cnt==FRAMES_PER_SAMPLE-1). fps_cnt increments on each frame_tick and wraps to 0 on a boundary. sample_out changes only on the cycle of a boundary, so the new value is seen by the modulators starting at frame_cnt==0.
- in_ready = (fifo_level != DEPTH). There is no full-bypass: a write while full is refused even if a pop occurs in the same cycle.
- Push and pop in the same cycle leave the level unchanged. Data is first-in first-out. Pointers wrap modulo DEPTH.
- FSM, evaluated only on sample boundaries:
  - IDLE: sample_out=MIDSCALE. If play_en & level>=DEPTH/2: pop head into sample_out and go to PLAY. Otherwise stay in IDLE. The FIFO keeps accepting writes while in IDLE.
  - PLAY:
    - If !play_en: sample_out=MIDSCALE, go to IDLE, no pop.
    - Else if level>0: pop head into sample_out and stay in PLAY.
    - Else (starved): hold the previous sample_out, set underrun=1, go to UNDERRUN.
  - UNDERRUN:
    - If !play_en: sample_out=MIDSCALE, go to IDLE.
    - Else if level>=DEPTH/2: pop into sample_out, go to PLAY.
    - Else: hold sample_out and stay in UNDERRUN.
- Between boundaries, play_en is ignored (no immediate mute). This keeps the current PWM period intact.
- underrun is sticky. clr_underrun clears it. If a set and a clear occur in the same cycle, set wins.
- The state encoding value 3 is unreachable; if it is ever entered, the FSM goes to IDLE on the next boundary.
- Latency: the first sample reaches sample_out at the first boundary after play_en=1 and level>=DEPTH/2, i.e. at most 256*FRAMES_PER_SAMPLE cycles later.

Test Plan:
1. Reset with ena=1, then hold rst_n=0 for 2 cycles -> sample_out=0x80, state=0, fifo_level=0, in_ready=1, underrun=0, frame_cnt=0.
2. Push 0x10,0x20,0x30,0x40 with DEPTH=4, then assert play_en -> in_ready=0 at level 4. At the first boundary (cycle 1023 after reset, default parameters): sample_out=0x10, state=PLAY, level=3. Next boundaries give 0x20, 0x30, 0x40 in order.
3. Continue test 2 without further pushes -> at the 5th boundary: state=UNDERRUN, underrun=1, sample_out held at 0x40. Push 0x55,0x66 -> next boundary: sample_out=0x55, state=PLAY. Pulse clr_underrun -> underrun=0.
4. Deassert play_en at frame_cnt=100 mid-sample -> sample_out unchanged until the next boundary, then 0x80 and state=IDLE. Remaining FIFO entries are retained (level unchanged).
5. Hold ena=0 for 50 cycles with in_valid=1 during PLAY -> frame_cnt, level, sample_out and state all frozen; in_ready=0; no push occurs.
6. With level=2, assert push and pop on the same boundary cycle -> level stays 2 and the popped value is the older entry. Also assert underrun set and clr_underrun together -> underrun=1.
